// File: rtl/ctrl_mc_pkg.sv
// Shared constants for the ctrl_mc multi-cycle controller: RV32I opcodes,
// one-hot state encodings and trap cause codes.
package ctrl_mc_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // One-hot so each Moore output reduces to a single state bit plus opcode qualifiers
    localparam logic [6:0] S_IDLE   = 7'b0000001;
    localparam logic [6:0] S_FETCH  = 7'b0000010;
    localparam logic [6:0] S_DECODE = 7'b0000100;
    localparam logic [6:0] S_EX     = 7'b0001000;
    localparam logic [6:0] S_MEM    = 7'b0010000;
    localparam logic [6:0] S_WB     = 7'b0100000;
    localparam logic [6:0] S_TRAP   = 7'b1000000;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/ctrl_mc_opdec.sv
// Combinational RV32I opcode classifier used by the ctrl_mc sequencer.
module ctrl_mc_opdec
    import ctrl_mc_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       writes_rd,
    output logic       illegal
);

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_LOAD:   is_load   = 1'b1;
            OPC_STORE:  is_store  = 1'b1;
            OPC_BRANCH: is_branch = 1'b1;
            OPC_JAL, OPC_JALR: is_jump = 1'b1;
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: ;
            default:    illegal   = 1'b1;
        endcase
        // MISC_MEM retires like an ALU op; its rd field is x0 in practice
        writes_rd = !(is_store || is_branch || illegal);
    end

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle RV32I control FSM with instruction/data memory handshakes and traps.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module ctrl_mc
    import ctrl_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
)(
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             halt,
    input  logic [6:0]       instr,
    input  logic             instr_valid,
    output logic             instr_req,
    input  logic             mem_valid,
    output logic             mem_req,
    output logic             mem_we,
    output logic             branch,
    output logic             reg_write,
    output logic             pc_write,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [6:0]      state;
    logic [6:0]      state_nxt;
    logic [6:0]      opcode;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;
    logic            is_load, is_store, is_branch, is_jump, writes_rd, illegal;

    ctrl_mc_opdec u_opdec (
        .opcode    (opcode),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .writes_rd (writes_rd),
        .illegal   (illegal)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  if (instr_valid) state_nxt = S_DECODE;
            S_DECODE: state_nxt = illegal ? S_TRAP : S_EX;
            S_EX:     state_nxt = (is_load || is_store) ? S_MEM : S_WB;
            // A response in the final allowed cycle still completes the access
            S_MEM: begin
                if (mem_valid)        state_nxt = S_WB;
                else if (timeout_hit) state_nxt = S_TRAP;
            end
            S_WB:     state_nxt = halt ? S_IDLE : S_FETCH;
            S_TRAP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state  <= S_IDLE;
            opcode <= '0;
            to_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && instr_valid)
                opcode <= instr;
            to_cnt <= (state == S_MEM) ? to_cnt + TO_W'(1) : '0;
        end
    end

    // Only an illegal opcode or a memory timeout can reach TRAP, so the cause follows the opcode
    assign instr_req  = (state == S_FETCH);
    assign mem_req    = (state == S_MEM);
    assign mem_we     = (state == S_MEM) && is_store;
    assign branch     = (state == S_EX) && (is_branch || is_jump);
    assign pc_write   = (state == S_WB);
    assign reg_write  = (state == S_WB) && writes_rd;
    assign trap       = (state == S_TRAP);
    assign trap_cause = (state != S_TRAP) ? CAUSE_NONE :
                        illegal           ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (res) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state != S_IDLE)
                cycle_q <= cycle_q + CNT_W'(1);
            if (state == S_WB)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_mc.sv
// Self-checking bench for ctrl_mc: directed scenarios followed by randomized
// instruction streams, checked cycle by cycle against a transaction-level model.
module tb_ctrl_mc;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic             clk = 1'b0;
    logic             res;
    logic             start;
    logic             halt;
    logic [6:0]       instr;
    logic             instr_valid;
    logic             instr_req;
    logic             mem_valid;
    logic             mem_req;
    logic             mem_we;
    logic             branch;
    logic             reg_write;
    logic             pc_write;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_cyc    = 0;
    int model_ret    = 0;

    logic [6:0] legal_tab [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};

    ctrl_mc #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .res         (res),
        .start       (start),
        .halt        (halt),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_req   (instr_req),
        .mem_valid   (mem_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .branch      (branch),
        .reg_write   (reg_write),
        .pc_write    (pc_write),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit op_legal(input logic [6:0] op);
        for (int i = 0; i < 10; i++)
            if (legal_tab[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected output bundle: {instr_req, mem_req, mem_we, branch, reg_write, pc_write, trap, trap_cause}
    function automatic logic [8:0] outs(input bit ireq, input bit mreq, input bit we, input bit br,
                                        input bit rw, input bit pw, input bit tr, input logic [1:0] cause);
        return {ireq, mreq, we, br, rw, pw, tr, cause};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the current cycle, accounts it in the counter model, then advances one clock
    task automatic step(input string tag, input logic [8:0] exp, input bit busy, input bit retire);
        check(tag, 32'({instr_req, mem_req, mem_we, branch, reg_write, pc_write, trap, trap_cause}),
              32'(exp));
`ifdef CTRL_PERF_CNT_EN
        check({tag, ".cycle_cnt"}, cycle_cnt, 32'(model_cyc));
        check({tag, ".instret_cnt"}, instret_cnt, 32'(model_ret));
`else
        check({tag, ".cycle_cnt"}, cycle_cnt, 32'd0);
        check({tag, ".instret_cnt"}, instret_cnt, 32'd0);
`endif
        if (busy) model_cyc++;
        if (retire) model_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_then_start(input int n_idle);
        for (int k = 0; k <= n_idle; k++) begin
            start       = (k == n_idle);
            halt        = 1'($urandom);
            instr_valid = 1'($urandom);
            mem_valid   = 1'($urandom);
            instr       = 7'($urandom);
            step("idle", 9'd0, 1'b0, 1'b0);
        end
    endtask

    // One instruction from FETCH entry; reset_at >= 0 pulses reset in that MEM cycle
    task automatic run_instr(input logic [6:0] op, input int iwait, input int mwait,
                             input bit halt_req, input int reset_at, output bit ended_idle);
        bit is_st, is_br, is_jmp, is_mem;
        is_st      = (op == 7'b0100011);
        is_br      = (op == 7'b1100011);
        is_jmp     = (op == 7'b1101111) || (op == 7'b1100111);
        is_mem     = is_st || (op == 7'b0000011);
        ended_idle = 1'b1;
        for (int k = 0; k <= iwait; k++) begin
            instr_valid = (k == iwait);
            instr       = (k == iwait) ? op : 7'($urandom);
            start       = 1'($urandom);
            halt        = 1'($urandom);
            mem_valid   = 1'($urandom);
            step("fetch", outs(1, 0, 0, 0, 0, 0, 0, 2'b00), 1'b1, 1'b0);
        end
        instr_valid = 1'($urandom);
        instr       = 7'($urandom);
        step("decode", 9'd0, 1'b1, 1'b0);
        if (!op_legal(op)) begin
            step("trap_illegal", outs(0, 0, 0, 0, 0, 0, 1, 2'b01), 1'b1, 1'b0);
            return;
        end
        mem_valid = 1'b0;
        step("ex", outs(0, 0, 0, is_br || is_jmp, 0, 0, 0, 2'b00), 1'b1, 1'b0);
        if (is_mem) begin
            for (int k = 0; k < MEM_TIMEOUT; k++) begin
                mem_valid   = (k == mwait);
                instr_valid = 1'($urandom);
                start       = 1'($urandom);
                halt        = 1'($urandom);
                if (k == reset_at) res = 1'b1;
                step("mem", outs(0, 1, is_st, 0, 0, 0, 0, 2'b00), 1'b1, 1'b0);
                if (k == reset_at) begin
                    res       = 1'b0;
                    model_cyc = 0;
                    model_ret = 0;
                    return;
                end
                if (k == mwait) break;
            end
            mem_valid = 1'b0;
            if (mwait >= MEM_TIMEOUT) begin
                step("trap_timeout", outs(0, 0, 0, 0, 0, 0, 1, 2'b10), 1'b1, 1'b0);
                return;
            end
        end
        halt  = halt_req;
        start = 1'($urandom);
        step("wb", outs(0, 0, 0, 0, !(is_st || is_br), 1, 0, 2'b00), 1'b1, 1'b1);
        halt       = 1'b0;
        ended_idle = halt_req;
    endtask

    initial begin
        bit         in_idle;
        logic [6:0] op;
        int         mw;
        int         rst_at;

        res         = 1'b1;
        start       = 1'b0;
        halt        = 1'b0;
        instr       = 7'd0;
        instr_valid = 1'b0;
        mem_valid   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        res = 1'b0;

        idle_then_start(0);
        run_instr(7'b0110011, 1, 0, 1'b1, -1, in_idle);
        idle_then_start(1);
        run_instr(7'b0000011, 0, 2, 1'b0, -1, in_idle);
        run_instr(7'b0100011, 0, 100, 1'b0, -1, in_idle);
        idle_then_start(0);
        run_instr(7'b1111111, 0, 0, 1'b0, -1, in_idle);
        idle_then_start(0);
        run_instr(7'b1100011, 0, 0, 1'b1, -1, in_idle);
        idle_then_start(0);
        run_instr(7'b0000011, 0, 2, 1'b0, 2, in_idle);
        idle_then_start(2);
        run_instr(7'b0100011, 2, MEM_TIMEOUT - 1, 1'b0, -1, in_idle);
        run_instr(7'b1101111, 0, 0, 1'b0, -1, in_idle);
        run_instr(7'b0001111, 0, 0, 1'b1, -1, in_idle);

        for (int n = 0; n < 150; n++) begin
            if (in_idle) idle_then_start($urandom_range(0, 2));
            if ($urandom_range(0, 9) < 7) op = legal_tab[$urandom_range(0, 9)];
            else                          op = 7'($urandom);
            mw     = ($urandom_range(0, 4) == 0) ? MEM_TIMEOUT + $urandom_range(0, 3)
                                                 : $urandom_range(0, MEM_TIMEOUT - 1);
            rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
            run_instr(op, $urandom_range(0, 3), mw, ($urandom_range(0, 3) == 0), rst_at, in_idle);
        end
        if (in_idle) idle_then_start(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
